corr_window_sequencer: RTL and testbench

//  Sequences one shared correlator accumulator for several requesters. Grants the

---
 rtl/corr_window_sequencer.sv | 158 +++++++++++++++
 tb/tb_corr_window_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/corr_window_sequencer.sv
// rtl/corr_window_sequencer.sv - round-robin sequencer for a shared windowed correlator (option: CORR_THRESH_EN)
module corr_window_sequencer #(
   parameter int N_REQ       = 2,
   parameter int WINDOW      = 16,
   parameter int CNT_W       = 8,
   parameter int FLAG_CYCLES = 2,
   parameter int CORR_W      = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [N_REQ-1:0]  Req,
   output logic [N_REQ-1:0]  Grant,
   output logic [N_REQ-1:0]  Done,
   input  logic              SampleValid,
   output logic              AccClr,
   output logic              AccEn,
   input  logic [CORR_W-1:0] CorrValue,
   output logic              RegEn,
   output logic [CORR_W-1:0] CorrOut,
   input  logic [CORR_W-1:0] Thresh,
   output logic              Flag,
   output logic              Busy
);

   localparam int PTR_W = $clog2(N_REQ);
   localparam int FC_W  = $clog2(FLAG_CYCLES) + 1;

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACCUM, S_LATCH, S_FLAG} state_t;

   state_t            state, state_nx;
   logic [PTR_W-1:0]  ptr;
   logic [CNT_W-1:0]  sample_cnt;
   logic [FC_W-1:0]   flag_cnt;
   logic [N_REQ-1:0]  win_onehot;
   logic [PTR_W-1:0]  win_idx;
   logic [PTR_W-1:0]  ptr_nx;
   logic              win_found;
   logic              last_sample;
   logic              last_flag;
   logic              hit;

   assign last_sample = SampleValid && (sample_cnt == CNT_W'(WINDOW - 1));
   assign last_flag   = (flag_cnt == FC_W'(FLAG_CYCLES - 1));
   assign ptr_nx      = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

   // Round-robin search: first requester at or after the pointer, wrapping to 0
   always_comb begin
      int idx;
      idx        = 0;
      win_onehot = '0;
      win_idx    = '0;
      win_found  = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!win_found && Req[idx]) begin
            win_found       = 1'b1;
            win_idx         = PTR_W'(idx);
            win_onehot[idx] = 1'b1;
         end
      end
   end

`ifdef CORR_THRESH_EN
   // Threshold compare is taken together with the result latch so Flag matches CorrOut
   always_ff @(posedge Clk) begin
      if (Reset)
         hit <= 1'b0;
      else if (state == S_LATCH)
         hit <= (CorrValue >= Thresh);
   end
`else
   logic thresh_unused;
   assign thresh_unused = ^Thresh;
   assign hit = 1'b1;
`endif

   // State register
   always_ff @(posedge Clk) begin
      if (Reset)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // Next-state and per-state strobes
   always_comb begin
      state_nx = state;
      AccClr   = 1'b0;
      AccEn    = 1'b0;
      RegEn    = 1'b0;
      Flag     = 1'b0;
      Done     = '0;
      Busy     = (state != S_IDLE);
      case (state)
         S_IDLE:  if (win_found) state_nx = S_CLEAR;
         S_CLEAR: begin
            AccClr   = 1'b1;
            state_nx = S_ACCUM;
         end
         S_ACCUM: begin
            AccEn = SampleValid;
            if (last_sample) state_nx = S_LATCH;
         end
         S_LATCH: begin
            RegEn    = 1'b1;
            state_nx = S_FLAG;
         end
         S_FLAG: begin
            Flag = hit;
            if (last_flag) begin
               Done     = Grant;
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Ownership, pointer, counters and result register
   always_ff @(posedge Clk) begin
      if (Reset) begin
         Grant      <= '0;
         ptr        <= '0;
         sample_cnt <= '0;
         flag_cnt   <= '0;
         CorrOut    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (win_found) begin
                  Grant <= win_onehot;
                  ptr   <= ptr_nx;
               end
            end
            S_CLEAR: begin
               sample_cnt <= '0;
               flag_cnt   <= '0;
            end
            S_ACCUM: begin
               if (SampleValid && !last_sample)
                  sample_cnt <= sample_cnt + 1'b1;
            end
            S_LATCH: CorrOut <= CorrValue;
            S_FLAG: begin
               if (last_flag) begin
                  Grant    <= '0;
                  flag_cnt <= '0;
               end else begin
                  flag_cnt <= flag_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_corr_window_sequencer.sv
// tb/tb_corr_window_sequencer.sv - directed bench for corr_window_sequencer (WINDOW=4, FLAG_CYCLES=2)
module tb_corr_window_sequencer;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [1:0]  Req;
   logic [1:0]  Grant;
   logic [1:0]  Done;
   logic        SampleValid;
   logic        AccClr;
   logic        AccEn;
   logic [15:0] CorrValue;
   logic        RegEn;
   logic [15:0] CorrOut;
   logic [15:0] Thresh;
   logic        Flag;
   logic        Busy;

   int checks = 0;
   int errors = 0;

   corr_window_sequencer #(
      .N_REQ(2), .WINDOW(4), .CNT_W(8), .FLAG_CYCLES(2), .CORR_W(16)
   ) dut (
      .Clk(Clk), .Reset(Reset), .Req(Req), .Grant(Grant), .Done(Done),
      .SampleValid(SampleValid), .AccClr(AccClr), .AccEn(AccEn),
      .CorrValue(CorrValue), .RegEn(RegEn), .CorrOut(CorrOut),
      .Thresh(Thresh), .Flag(Flag), .Busy(Busy)
   );

   // 100 MHz-style free-running clock
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #2;
   endtask

   // One full operation starting in an IDLE cycle; returns at the next IDLE cycle
   task automatic run_op(input logic [1:0] req_v, input logic [1:0] exp_grant,
                         input bit toggle, input logic [15:0] cv, input logic [15:0] th,
                         input bit exp_hit, input logic [1:0] req_after);
      logic exp_flag;
`ifdef CORR_THRESH_EN
      exp_flag = exp_hit;
`else
      exp_flag = 1'b1;
`endif
      Req = req_v; SampleValid = 1'b1; Thresh = th; CorrValue = 16'hdead;
      #1;
      chk("idle_busy", Busy, 0);
      chk("idle_grant", Grant, 0);
      chk("idle_done", Done, 0);
      chk("idle_flag", Flag, 0);
      tick();
      Req = req_after;
      #1;
      chk("clear_grant", Grant, exp_grant);
      chk("clear_accclr", AccClr, 1);
      chk("clear_accen", AccEn, 0);
      chk("clear_busy", Busy, 1);
      tick();
      for (int i = 0; i < (toggle ? 7 : 4); i++) begin
         SampleValid = toggle ? ~i[0] : 1'b1;
         #1;
         chk("accum_accen", AccEn, SampleValid);
         chk("accum_regen", RegEn, 0);
         chk("accum_grant", Grant, exp_grant);
         tick();
      end
      SampleValid = 1'b0; CorrValue = cv;
      #1;
      chk("latch_regen", RegEn, 1);
      chk("latch_accen", AccEn, 0);
      chk("latch_flag", Flag, 0);
      tick();
      CorrValue = 16'hdead;
      #1;
      chk("flag1_flag", Flag, exp_flag);
      chk("flag1_corrout", CorrOut, cv);
      chk("flag1_done", Done, 0);
      chk("flag1_grant", Grant, exp_grant);
      tick();
      #1;
      chk("flag2_flag", Flag, exp_flag);
      chk("flag2_done", Done, exp_grant);
      chk("flag2_grant", Grant, exp_grant);
      tick();
   endtask

   initial begin
      Reset = 1'b1; Req = 2'b00; SampleValid = 1'b0; CorrValue = 16'h0; Thresh = 16'd100;
      repeat (3) tick();
      Reset = 1'b0;
      #1;
      chk("rst_grant", Grant, 0);
      chk("rst_done", Done, 0);
      chk("rst_accclr", AccClr, 0);
      chk("rst_accen", AccEn, 0);
      chk("rst_regen", RegEn, 0);
      chk("rst_flag", Flag, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_corrout", CorrOut, 0);
      tick();

      // Single request; owner drops Req in CLEAR, no regrant afterwards
      run_op(2'b01, 2'b01, 1'b0, 16'h1234, 16'd100, 1'b1, 2'b00);
      #1;
      chk("norequest_busy", Busy, 0);
      tick();
      #1;
      chk("norequest_busy2", Busy, 0);
      chk("norequest_grant", Grant, 0);
      tick();

      // Both requesting: pointer is 1 after the grant to 01, so 10,01,10
      run_op(2'b11, 2'b10, 1'b0, 16'd99, 16'd100, 1'b0, 2'b11);
      run_op(2'b11, 2'b01, 1'b0, 16'd100, 16'd100, 1'b1, 2'b11);
      run_op(2'b11, 2'b10, 1'b0, 16'h0042, 16'h0043, 1'b0, 2'b00);

      // Toggling SampleValid: 4 valid samples over 7 ACCUM cycles
      run_op(2'b10, 2'b10, 1'b1, 16'hbeef, 16'hbeef, 1'b1, 2'b00);

      // Reset in the middle of ACCUM
      Req = 2'b01; SampleValid = 1'b1;
      #1;
      chk("pre_rst_busy", Busy, 0);
      tick();
      Req = 2'b00;
      #1;
      chk("pre_rst_grant", Grant, 2'b01);
      tick();
      #1;
      chk("pre_rst_accen", AccEn, 1);
      Reset = 1'b1;
      tick();
      #1;
      chk("midrst_grant", Grant, 0);
      chk("midrst_busy", Busy, 0);
      chk("midrst_accen", AccEn, 0);
      chk("midrst_accclr", AccClr, 0);
      chk("midrst_regen", RegEn, 0);
      chk("midrst_flag", Flag, 0);
      chk("midrst_done", Done, 0);
      chk("midrst_corrout", CorrOut, 0);
      Reset = 1'b0;

      // Pointer back at 0: 11 grants 01, then 10 grants 10
      run_op(2'b11, 2'b01, 1'b0, 16'h0100, 16'h00ff, 1'b1, 2'b00);
      run_op(2'b10, 2'b10, 1'b0, 16'h7777, 16'h8000, 1'b0, 2'b00);
      #1;
      chk("final_busy", Busy, 0);
      chk("final_grant", Grant, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
